// File: rtl/run_group_counter.sv
// run_group_counter
// Counts maximal runs of POLARITY bits on a bit-valid qualified serial input.
// Runs shorter than MIN_RUN are discarded; qualifying runs bump a saturating
// group counter, update last/longest run length and fire a one-cycle run_done.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  S_IDLE | no run open, run_len = 0
//  S_RUN  | run open, run_len >= 1 (saturates at all-ones)
module run_group_counter #(
   parameter int COUNT_W  = 8,
   parameter int LEN_W    = 8,
   parameter int MIN_RUN  = 1,
   parameter bit POLARITY = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               din,
   input  logic               en,
   input  logic               flush,
   input  logic               clr,
   output logic [COUNT_W-1:0] count,
   output logic               count_sat,
   output logic [LEN_W-1:0]   run_len,
   output logic [LEN_W-1:0]   last_len,
   output logic [LEN_W-1:0]   max_len,
   output logic               in_run,
   output logic               run_done
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   localparam logic [LEN_W-1:0]   LEN_MAX   = '1;
   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
   localparam logic [LEN_W-1:0]   MIN_L     = LEN_W'(MIN_RUN);
   localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);

   state_t             state, state_nxt;
   logic [LEN_W-1:0]   run_len_nxt;
   logic [LEN_W-1:0]   len_inc;
   logic [LEN_W-1:0]   close_len;
   logic               close_evt;
   logic               qualify;
   logic               match_s;
   logic               nomatch_s;
   logic [COUNT_W-1:0] count_inc;

   assign match_s   = en && (din == POLARITY);
   assign nomatch_s = en && (din != POLARITY);
   assign len_inc   = (run_len == LEN_MAX) ? run_len : run_len + LEN_ONE;
   assign count_inc = (count == COUNT_MAX) ? count : count + COUNT_W'(1);
   assign qualify   = close_evt && (close_len >= MIN_L);

   // State register; clr behaves like a reset of the run tracker
   always_ff @(posedge clk) begin
      if (rst || clr) state <= S_IDLE;
      else            state <= state_nxt;
   end

   // Next state, next run length and close detection
   always_comb begin
      state_nxt   = state;
      run_len_nxt = run_len;
      close_evt   = 1'b0;
      close_len   = '0;
      case (state)
         S_IDLE: begin
            if (match_s) begin
               if (flush) begin
                  // one-bit run opens and closes on the same edge
                  close_evt = 1'b1;
                  close_len = LEN_ONE;
               end else begin
                  state_nxt   = S_RUN;
                  run_len_nxt = LEN_ONE;
               end
            end
         end
         S_RUN: begin
            if (match_s) begin
               if (flush) begin
                  // append the matching sample before closing
                  close_evt   = 1'b1;
                  close_len   = len_inc;
                  state_nxt   = S_IDLE;
                  run_len_nxt = '0;
               end else begin
                  run_len_nxt = len_inc;
               end
            end else if (nomatch_s || flush) begin
               // non-matching sample and flush together still close only once
               close_evt   = 1'b1;
               close_len   = run_len;
               state_nxt   = S_IDLE;
               run_len_nxt = '0;
            end
         end
         default: begin
            state_nxt   = S_IDLE;
            run_len_nxt = '0;
         end
      endcase
   end

   // Output decode from the state register
   always_comb begin
      in_run = (state == S_RUN);
   end

   // Run length, statistics and completion pulse
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         run_len   <= '0;
         count     <= '0;
         count_sat <= 1'b0;
         last_len  <= '0;
         max_len   <= '0;
         run_done  <= 1'b0;
      end else begin
         run_len  <= run_len_nxt;
         run_done <= qualify;
         if (qualify) begin
            count     <= count_inc;
            count_sat <= count_sat | (count_inc == COUNT_MAX);
            last_len  <= close_len;
            if (close_len > max_len) max_len <= close_len;
         end
      end
   end

endmodule

// File: tb/tb_run_group_counter.sv
// Directed bench for run_group_counter: a vector table for the default
// configuration plus short sequences for MIN_RUN, POLARITY and saturation.
module tb_run_group_counter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din = 1'b0;
   logic en = 1'b0;
   logic flush = 1'b0;
   logic clr = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // default configuration
   logic [7:0] c0_count, c0_run_len, c0_last_len, c0_max_len;
   logic       c0_sat, c0_in_run, c0_done;
   run_group_counter u0 (
      .clk(clk), .rst(rst), .din(din), .en(en), .flush(flush), .clr(clr),
      .count(c0_count), .count_sat(c0_sat), .run_len(c0_run_len),
      .last_len(c0_last_len), .max_len(c0_max_len), .in_run(c0_in_run),
      .run_done(c0_done));

   // MIN_RUN = 3
   logic [7:0] c1_count, c1_run_len, c1_last_len, c1_max_len;
   logic       c1_sat, c1_in_run, c1_done;
   run_group_counter #(.MIN_RUN(3)) u_min (
      .clk(clk), .rst(rst), .din(din), .en(en), .flush(flush), .clr(clr),
      .count(c1_count), .count_sat(c1_sat), .run_len(c1_run_len),
      .last_len(c1_last_len), .max_len(c1_max_len), .in_run(c1_in_run),
      .run_done(c1_done));

   // POLARITY = 0
   logic [7:0] c2_count, c2_run_len, c2_last_len, c2_max_len;
   logic       c2_sat, c2_in_run, c2_done;
   run_group_counter #(.POLARITY(1'b0)) u_pol (
      .clk(clk), .rst(rst), .din(din), .en(en), .flush(flush), .clr(clr),
      .count(c2_count), .count_sat(c2_sat), .run_len(c2_run_len),
      .last_len(c2_last_len), .max_len(c2_max_len), .in_run(c2_in_run),
      .run_done(c2_done));

   // narrow widths for saturation
   logic [1:0] c3_count;
   logic [2:0] c3_run_len, c3_last_len, c3_max_len;
   logic       c3_sat, c3_in_run, c3_done;
   run_group_counter #(.COUNT_W(2), .LEN_W(3)) u_sat (
      .clk(clk), .rst(rst), .din(din), .en(en), .flush(flush), .clr(clr),
      .count(c3_count), .count_sat(c3_sat), .run_len(c3_run_len),
      .last_len(c3_last_len), .max_len(c3_max_len), .in_run(c3_in_run),
      .run_done(c3_done));

   typedef struct {
      logic r, e, d, f, c;
      int   cnt, rl, ll, ml;
      logic ir, rd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic r, e, d, f, c,
                              input int cnt, rl, ll, ml,
                              input logic ir, rd);
      vec_t x;
      x.r = r; x.e = e; x.d = d; x.f = f; x.c = c;
      x.cnt = cnt; x.rl = rl; x.ll = ll; x.ml = ml; x.ir = ir; x.rd = rd;
      return x;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // drive inputs away from the edge, sample 1 time unit after it
   task automatic apply(input logic r, e, d, f, c);
      @(negedge clk);
      rst = r; en = e; din = d; flush = f; clr = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic b_min[7];
      logic d_min[7];
      b_min = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      d_min = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      //          r e d f c  cnt rl ll ml ir rd
      vecs.push_back(v(1,0,0,0,0, 0, 0, 0, 0, 0, 0));
      // basic stream 0,1,1,0,1,0
      vecs.push_back(v(0,1,0,0,0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(0,1,1,0,0, 0, 1, 0, 0, 1, 0));
      vecs.push_back(v(0,1,1,0,0, 0, 2, 0, 0, 1, 0));
      vecs.push_back(v(0,1,0,0,0, 1, 0, 2, 2, 0, 1));
      vecs.push_back(v(0,1,1,0,0, 1, 1, 2, 2, 1, 0));
      vecs.push_back(v(0,1,0,0,0, 2, 0, 1, 2, 0, 1));
      vecs.push_back(v(0,0,0,0,0, 2, 0, 1, 2, 0, 0));
      // flush on consecutive single-bit runs: back-to-back pulses
      vecs.push_back(v(0,1,1,1,0, 3, 0, 1, 2, 0, 1));
      vecs.push_back(v(0,1,1,1,0, 4, 0, 1, 2, 0, 1));
      vecs.push_back(v(0,0,0,0,0, 4, 0, 1, 2, 0, 0));
      // run of 2, then flush with matching sample appends it
      vecs.push_back(v(0,1,1,0,0, 4, 1, 1, 2, 1, 0));
      vecs.push_back(v(0,1,1,0,0, 4, 2, 1, 2, 1, 0));
      vecs.push_back(v(0,1,1,1,0, 5, 0, 3, 3, 0, 1));
      vecs.push_back(v(0,0,0,1,0, 5, 0, 3, 3, 0, 0));
      // flush with non-matching sample closes once
      vecs.push_back(v(0,1,1,0,0, 5, 1, 3, 3, 1, 0));
      vecs.push_back(v(0,1,0,1,0, 6, 0, 1, 3, 0, 1));
      vecs.push_back(v(0,0,0,0,0, 6, 0, 1, 3, 0, 0));
      // clr mid-run ignores its sample, then 1,0 counts from one
      vecs.push_back(v(0,1,1,0,0, 6, 1, 1, 3, 1, 0));
      vecs.push_back(v(0,1,1,0,0, 6, 2, 1, 3, 1, 0));
      vecs.push_back(v(0,1,1,0,1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(0,1,1,0,0, 0, 1, 0, 0, 1, 0));
      vecs.push_back(v(0,1,0,0,0, 1, 0, 1, 1, 0, 1));
      // en=0 holds the run; flush without a sample closes it
      vecs.push_back(v(0,1,1,0,0, 1, 1, 1, 1, 1, 0));
      vecs.push_back(v(0,0,0,0,0, 1, 1, 1, 1, 1, 0));
      vecs.push_back(v(0,1,1,0,0, 1, 2, 1, 1, 1, 0));
      vecs.push_back(v(0,0,0,1,0, 2, 0, 2, 2, 0, 1));
      // reach count=5, rst mid-run, new run counts from one
      vecs.push_back(v(0,1,1,1,0, 3, 0, 1, 2, 0, 1));
      vecs.push_back(v(0,1,1,1,0, 4, 0, 1, 2, 0, 1));
      vecs.push_back(v(0,1,1,1,0, 5, 0, 1, 2, 0, 1));
      vecs.push_back(v(0,1,1,0,0, 5, 1, 1, 2, 1, 0));
      vecs.push_back(v(0,1,1,0,0, 5, 2, 1, 2, 1, 0));
      vecs.push_back(v(1,1,1,0,0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(0,1,1,0,0, 0, 1, 0, 0, 1, 0));
      vecs.push_back(v(0,1,0,0,0, 1, 0, 1, 1, 0, 1));

      foreach (vecs[i]) begin
         apply(vecs[i].r, vecs[i].e, vecs[i].d, vecs[i].f, vecs[i].c);
         chk($sformatf("v%0d count", i),    int'(c0_count),    vecs[i].cnt);
         chk($sformatf("v%0d run_len", i),  int'(c0_run_len),  vecs[i].rl);
         chk($sformatf("v%0d last_len", i), int'(c0_last_len), vecs[i].ll);
         chk($sformatf("v%0d max_len", i),  int'(c0_max_len),  vecs[i].ml);
         chk($sformatf("v%0d in_run", i),   int'(c0_in_run),   int'(vecs[i].ir));
         chk($sformatf("v%0d run_done", i), int'(c0_done),     int'(vecs[i].rd));
         chk($sformatf("v%0d count_sat", i), int'(c0_sat),     0);
      end

      // MIN_RUN=3: stream 1,1,0,1,1,1,0
      apply(1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         apply(0, 1, b_min[i], 0, 0);
         chk($sformatf("min step%0d run_done", i), int'(c1_done), int'(d_min[i]));
         if (i == 2) chk("min short run discarded", int'(c1_count), 0);
      end
      chk("min count",    int'(c1_count),    1);
      chk("min last_len", int'(c1_last_len), 3);
      chk("min max_len",  int'(c1_max_len),  3);
      chk("min run_len",  int'(c1_run_len),  0);

      // POLARITY=0 with en gating
      apply(1, 0, 0, 0, 0);
      apply(0, 1, 0, 0, 0);
      chk("pol run_len open", int'(c2_run_len), 1);
      for (int i = 0; i < 3; i++) begin
         apply(0, 0, 1, 0, 0);
         chk($sformatf("pol gated%0d in_run", i),   int'(c2_in_run), 1);
         chk($sformatf("pol gated%0d run_done", i), int'(c2_done),   0);
         chk($sformatf("pol gated%0d run_len", i),  int'(c2_run_len), 1);
      end
      apply(0, 1, 0, 0, 0);
      chk("pol run_len grow", int'(c2_run_len), 2);
      apply(0, 1, 1, 0, 0);
      chk("pol count",    int'(c2_count),    1);
      chk("pol last_len", int'(c2_last_len), 2);
      chk("pol run_done", int'(c2_done),     1);
      chk("pol in_run",   int'(c2_in_run),   0);

      // saturation, COUNT_W=2 LEN_W=3
      apply(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         apply(0, 1, 1, 0, 0);
         apply(0, 1, 0, 0, 0);
         if (i == 1) begin
            chk("sat count at 2", int'(c3_count), 2);
            chk("sat flag at 2",  int'(c3_sat),   0);
         end
         if (i == 2) chk("sat flag at 3", int'(c3_sat), 1);
      end
      chk("sat count held", int'(c3_count), 3);
      chk("sat flag held",  int'(c3_sat),   1);
      for (int i = 0; i < 10; i++) begin
         apply(0, 1, 1, 0, 0);
         if (i == 6) chk("sat run_len at 7", int'(c3_run_len), 7);
      end
      chk("sat run_len held", int'(c3_run_len), 7);
      apply(0, 1, 0, 0, 0);
      chk("sat last_len", int'(c3_last_len), 7);
      chk("sat max_len",  int'(c3_max_len),  7);
      chk("sat run_done", int'(c3_done),     1);
      chk("sat count end", int'(c3_count),   3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/run_group_counter.md
# run_group_counter

Parametrised run/group counter for a serial bit stream. It counts maximal runs of a chosen polarity whose length meets a programmable minimum, and tracks the current, last and longest run lengths. A one-cycle completion pulse marks each counted run. It sits directly on a sampled serial input (bit-valid qualified) and feeds status registers or downstream framing logic.

## Interface
- COUNT_W, 8: width of group counter.
- LEN_W, 8: width of run-length registers.
- MIN_RUN, 1: minimum run length counted as a group; legal range 1 … 2^LEN_W−1.
- POLARITY, 1: bit value forming a run (1 = runs of ones, 0 = runs of zeros).
- clk, input, 1: the single clock; all logic rising-edge.
- rst, input, 1: reset, synchronous, active-high.
- din, input, 1: serial data bit.
- en, input, 1: din is sampled only when en=1.
- flush, input, 1: close any run in progress (end of stream).
- clr, input, 1: synchronous clear of all counters and statistics.
- count, output, COUNT_W: number of qualifying runs closed; saturating.
- count_sat, output, 1: sticky; set when count reaches 2^COUNT_W−1.
- run_len, output, LEN_W: length of run in progress (0 when none); saturating.
- last_len, output, LEN_W: length of the most recent qualifying run.
- max_len, output, LEN_W: longest qualifying run since reset/clr.
- in_run, output, 1: high while a run is open (state RUN).
- run_done, output, 1: one-cycle pulse after a qualifying run closes.

## Operation
- Accepted sample: en=1 at a rising edge. A matching sample has din==POLARITY.
- Two-state FSM:
  - IDLE (run_len=0).
  - RUN (run_len≥1).
- IDLE transitions:
  - Matching sample → RUN, run_len=1.
  - Non-matching sample or no sample → stay in IDLE.
- RUN transitions:
  - Matching sample → run_len+1, saturating at 2^LEN_W−1.
  - Non-matching sample → close run → IDLE, run_len=0.
  - No sample → hold.
- Close event, when length L ≥ MIN_RUN:
  - count+1, saturating; count_sat set on reaching all-ones.
  - last_len=L.
  - max_len=L if L>max_len.
  - run_done=1 for the next cycle.
- Close event, when L < MIN_RUN: run is discarded; no statistics change and no run_done.
- flush=1 in RUN: closes the run at that edge.
  - If an accepted matching sample arrives in the same cycle, it is appended first; L = run_len+1, saturating.
  - If an accepted non-matching sample arrives in the same cycle, there is a single close, not two.
- flush=1 in IDLE:
  - With an accepted matching sample: a run of length 1 opens and closes at once (counted if MIN_RUN=1).
  - Otherwise no effect.
- clr=1, priority over en/flush:
  - count, count_sat, run_len, last_len and max_len go to 0; state → IDLE; run_done=0.
  - The sample in that cycle is ignored.
- rst: same effect as clr, with highest priority.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- Reset values: count=0, count_sat=0, run_len=0, last_len=0, max_len=0, in_run=0, run_done=0.
- run_len and in_run reflect a sample from the edge following its acceptance (latency 1).
- Close edge: count, last_len, max_len and run_done all update on the edge that accepts the terminating sample (or flush). run_done is high for exactly that following cycle.
- Back-to-back closes (e.g. 1,0,1,0 with en every cycle, or flush on consecutive single-bit runs) give back-to-back run_done pulses. run_done is never stretched.
- en=0 cycles are transparent: the run neither grows nor closes.
- rst or clr mid-run: the partial run is lost. The next matching sample starts a new run of length 1.

## Test plan
- Basic count (defaults): rst, then en=1 stream 0,1,1,0,1,0 → run_done pulses twice; final count=2, last_len=1, max_len=2, run_len=0.
- Minimum length (MIN_RUN=3): stream 1,1,0,1,1,1,0 → only one run_done; count=1, last_len=3, max_len=3.
- en gating and POLARITY=0: en=1 din=0; en=0 din=1 for 3 cycles; en=1 din=0; en=1 din=1 → one run of length 2; count=1, no close during en=0.
- Saturation (COUNT_W=2, LEN_W=3):
  - 5 single-bit runs → count=3, count_sat=1.
  - Then 10 ones and a 0 → run_len holds 7; last_len=7.
- Flush and clr:
  - Run of 2 ones, then flush with en=1 din=1 → last_len=3, count+1, single run_done.
  - clr asserted mid-run → all stats 0, no run_done; next 1,0 → count=1.
- rst mid-run with count=5: all outputs 0 on the next cycle. A following run counts from 1.
